// File: rtl/bus_arbiter_rr_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr_if
// Groups the request/grant handshake and the steered address/command/data
// paths between the SDRAM masters, the arbiter and the SDRAM controller.
//
// Signals:
//   bus_request   per-master level request, held for the whole transfer
//   m_addr        packed master addresses, master i at [i*ADDR_W +: ADDR_W]
//   m_cmd         packed master commands,  master i at [i*CMD_W  +: CMD_W]
//   m_dataout     packed master write data, master i at [i*DATA_W +: DATA_W]
//   sdram_dataout SDRAM read data
//   bus_grant     one-hot registered grant
//   grant_valid   any grant active
//   grant_id      index of current owner (0 when no grant)
//   m_datain      read data returned on the owner's slice only
//   sdram_addr / sdram_cmd / sdram_datain  owner's fields towards SDRAM
//
// Modports:
//   slave   arbiter side (consumes requests, produces grants and steering)
//   master  requester/SDRAM side (drives requests, observes grants)
// -----------------------------------------------------------------------------
interface bus_arbiter_rr_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_W        = 2,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int CMD_W       = 3
);
  logic [NUM_MASTERS-1:0]        bus_request;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS*CMD_W-1:0]  m_cmd;
  logic [NUM_MASTERS*DATA_W-1:0] m_dataout;
  logic [DATA_W-1:0]             sdram_dataout;
  logic [NUM_MASTERS-1:0]        bus_grant;
  logic                          grant_valid;
  logic [ID_W-1:0]               grant_id;
  logic [NUM_MASTERS*DATA_W-1:0] m_datain;
  logic [ADDR_W-1:0]             sdram_addr;
  logic [CMD_W-1:0]              sdram_cmd;
  logic [DATA_W-1:0]             sdram_datain;

  modport slave (
    input  bus_request, m_addr, m_cmd, m_dataout, sdram_dataout,
    output bus_grant, grant_valid, grant_id, m_datain,
           sdram_addr, sdram_cmd, sdram_datain
  );

  modport master (
    output bus_request, m_addr, m_cmd, m_dataout, sdram_dataout,
    input  bus_grant, grant_valid, grant_id, m_datain,
           sdram_addr, sdram_cmd, sdram_datain
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
// N-master SDRAM bus arbiter with round-robin or fixed-priority selection and a
// grant hold limit. The owner is preempted after MAX_HOLD cycles when another
// master is waiting. Every ownership change passes through a one-cycle
// RELEASE turnaround with the bus idle. The owner's addr/cmd/data are steered
// to SDRAM and SDRAM read data is returned only on the owner's slice.
//
// Ports:
//   clk0   clock, all state on rising edge
//   reset  synchronous active-high reset
//   bus    bus_arbiter_rr_if.slave (requests, grants, datapath)
// -----------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_W        = 2,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int CMD_W       = 3,
  parameter int MAX_HOLD    = 16,
  parameter int PRIO_MODE   = 0
) (
  input  logic            clk0,
  input  logic            reset,
  bus_arbiter_rr_if.slave bus
);

  localparam int                     HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0]      HOLD_ONE  = HOLD_W'(1);
  localparam logic [ID_W-1:0]        PTR_INIT  = ID_W'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT_0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                 state_r, state_n_s;
  logic [NUM_MASTERS-1:0] grant_r, grant_n_s;
  logic [ID_W-1:0]        grant_id_r, grant_id_n_s;
  logic [HOLD_W-1:0]      hold_cnt_r, hold_cnt_n_s;
  logic [ID_W-1:0]        rr_ptr_r, rr_ptr_n_s;

  logic                   win_found_s;
  logic [ID_W-1:0]        win_id_s;
  logic                   owner_req_s;
  logic                   other_req_s;

  logic [ADDR_W-1:0]             addr_s;
  logic [CMD_W-1:0]              cmd_s;
  logic [DATA_W-1:0]             wdata_s;
  logic [NUM_MASTERS*DATA_W-1:0] rdata_s;

  // k-th candidate in search order: plain index for fixed priority,
  // otherwise rotating from the master after the last winner.
  function automatic logic [ID_W-1:0] cand_idx(input logic [ID_W-1:0] ptr, input int k);
    int raw;
    if (PRIO_MODE != 0) begin
      raw = k;
    end else begin
      raw = (int'(ptr) + 1 + k) % NUM_MASTERS;
    end
    return ID_W'(raw);
  endfunction

  // Winner search: first asserted request in candidate order.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = {ID_W{1'b0}};
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!win_found_s && bus.bus_request[cand_idx(rr_ptr_r, k)]) begin
        win_found_s = 1'b1;
        win_id_s    = cand_idx(rr_ptr_r, k);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Owner still requesting / anyone else waiting.
  always_comb begin
    owner_req_s = |(bus.bus_request & grant_r);
    other_req_s = |(bus.bus_request & ~grant_r);
  end

  // Next-state and next-grant logic.
  always_comb begin
    state_n_s    = state_r;
    grant_n_s    = grant_r;
    grant_id_n_s = grant_id_r;
    hold_cnt_n_s = hold_cnt_r;
    rr_ptr_n_s   = rr_ptr_r;
    case (state_r)
      // IDLE and RELEASE both hand the bus to the next winner if any.
      ST_IDLE, ST_RELEASE: begin
        if (win_found_s) begin
          state_n_s    = ST_GRANT;
          grant_n_s    = ONE_HOT_0 << win_id_s;
          grant_id_n_s = win_id_s;
          hold_cnt_n_s = {HOLD_W{1'b0}};
          rr_ptr_n_s   = win_id_s;
        end else begin
          state_n_s    = ST_IDLE;
          grant_n_s    = {NUM_MASTERS{1'b0}};
          grant_id_n_s = {ID_W{1'b0}};
          hold_cnt_n_s = {HOLD_W{1'b0}};
        end
      end
      ST_GRANT: begin
        // Release on owner drop, or preempt once the hold budget is spent
        // and someone else is waiting.
        if (!owner_req_s || ((hold_cnt_r == HOLD_LAST) && other_req_s)) begin
          state_n_s    = ST_RELEASE;
          grant_n_s    = {NUM_MASTERS{1'b0}};
          grant_id_n_s = {ID_W{1'b0}};
          hold_cnt_n_s = {HOLD_W{1'b0}};
        end else begin
          state_n_s = ST_GRANT;
          if (hold_cnt_r != HOLD_LAST) begin
            hold_cnt_n_s = hold_cnt_r + HOLD_ONE;
          end else begin
            hold_cnt_n_s = hold_cnt_r;
          end
        end
      end
      default: begin
        state_n_s    = ST_IDLE;
        grant_n_s    = {NUM_MASTERS{1'b0}};
        grant_id_n_s = {ID_W{1'b0}};
        hold_cnt_n_s = {HOLD_W{1'b0}};
        rr_ptr_n_s   = PTR_INIT;
      end
    endcase
  end

  // Arbiter state registers with synchronous reset.
  always_ff @(posedge clk0) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      grant_r    <= {NUM_MASTERS{1'b0}};
      grant_id_r <= {ID_W{1'b0}};
      hold_cnt_r <= {HOLD_W{1'b0}};
      rr_ptr_r   <= PTR_INIT;
    end else begin
      state_r    <= state_n_s;
      grant_r    <= grant_n_s;
      grant_id_r <= grant_id_n_s;
      hold_cnt_r <= hold_cnt_n_s;
      rr_ptr_r   <= rr_ptr_n_s;
    end
  end

  // Datapath steering keyed on the registered one-hot grant; an empty grant
  // yields all-zero outputs, which covers IDLE and RELEASE.
  always_comb begin
    addr_s  = {ADDR_W{1'b0}};
    cmd_s   = {CMD_W{1'b0}};
    wdata_s = {DATA_W{1'b0}};
    rdata_s = {(NUM_MASTERS*DATA_W){1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      addr_s  = addr_s  | (grant_r[i] ? bus.m_addr[i*ADDR_W +: ADDR_W]    : {ADDR_W{1'b0}});
      cmd_s   = cmd_s   | (grant_r[i] ? bus.m_cmd[i*CMD_W +: CMD_W]       : {CMD_W{1'b0}});
      wdata_s = wdata_s | (grant_r[i] ? bus.m_dataout[i*DATA_W +: DATA_W] : {DATA_W{1'b0}});
      rdata_s[i*DATA_W +: DATA_W] = grant_r[i] ? bus.sdram_dataout : {DATA_W{1'b0}};
    end
  end

  assign bus.bus_grant    = grant_r;
  assign bus.grant_valid  = |grant_r;
  assign bus.grant_id     = grant_id_r;
  assign bus.sdram_addr   = addr_s;
  assign bus.sdram_cmd    = cmd_s;
  assign bus.sdram_datain = wdata_s;
  assign bus.m_datain     = rdata_s;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_rr
// Drives a round-robin and a fixed-priority arbiter (MAX_HOLD=4) with the same
// stimulus. A reference model tracks owner / cycles owned / last winner per
// arbiter; each driven cycle pushes the expected post-edge outputs into a
// queue, and a monitor pops and compares after every rising edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_rr;
  localparam int N      = 4;
  localparam int ID_W   = 2;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int CMD_W  = 3;
  localparam int MH     = 4;

  logic clk0;
  logic reset;

  bus_arbiter_rr_if #(.NUM_MASTERS(N), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_W(CMD_W)) if_rr ();
  bus_arbiter_rr_if #(.NUM_MASTERS(N), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_W(CMD_W)) if_fp ();

  bus_arbiter_rr #(.NUM_MASTERS(N), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_W(CMD_W),
                   .MAX_HOLD(MH), .PRIO_MODE(0)) dut_rr (.clk0(clk0), .reset(reset), .bus(if_rr));
  bus_arbiter_rr #(.NUM_MASTERS(N), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_W(CMD_W),
                   .MAX_HOLD(MH), .PRIO_MODE(1)) dut_fp (.clk0(clk0), .reset(reset), .bus(if_fp));

  typedef struct packed {
    logic [N-1:0]        grant;
    logic [ID_W-1:0]     gid;
    logic [ADDR_W-1:0]   addr;
    logic [CMD_W-1:0]    cmd;
    logic [DATA_W-1:0]   sdin;
    logic [N*DATA_W-1:0] mdin;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fp[$];

  int n_err = 0;
  int n_chk = 0;

  // reference model state: index 0 = round-robin, 1 = fixed priority
  int m_owner[2];
  int m_cyc[2];
  int m_last[2];

  logic [N-1:0]        drv_req;
  logic [N*ADDR_W-1:0] drv_addr;
  logic [N*CMD_W-1:0]  drv_cmd;
  logic [N*DATA_W-1:0] drv_wdata;
  logic [DATA_W-1:0]   drv_rdata;

  bit   rec_order = 1'b0;
  bit   prev_valid_rr = 1'b0;
  int   seen_ids[$];

  initial begin
    clk0 = 1'b0;
    forever #5 clk0 = ~clk0;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int pick(input int d, input logic [N-1:0] req);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (d == 1) ? (k - 1) : ((m_last[d] + k) % N);
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input int d, input logic [N-1:0] req, input logic rst);
    bit others;
    int w;
    if (rst) begin
      m_owner[d] = -1;
      m_cyc[d]   = 0;
      m_last[d]  = N - 1;
    end else if (m_owner[d] >= 0) begin
      others = 1'b0;
      for (int k = 0; k < N; k++) if (k != m_owner[d] && req[k]) others = 1'b1;
      if (!req[m_owner[d]] || (m_cyc[d] >= MH && others)) begin
        m_owner[d] = -1;
        m_cyc[d]   = 0;
      end else begin
        m_cyc[d]++;
      end
    end else begin
      w = pick(d, req);
      if (w >= 0) begin
        m_owner[d] = w;
        m_cyc[d]   = 1;
        m_last[d]  = w;
      end
    end
  endtask

  function automatic exp_t make_exp(input int owner);
    exp_t e;
    e = '0;
    if (owner >= 0) begin
      e.grant[owner] = 1'b1;
      e.gid  = ID_W'(owner);
      e.addr = drv_addr[owner*ADDR_W +: ADDR_W];
      e.cmd  = drv_cmd[owner*CMD_W +: CMD_W];
      e.sdin = drv_wdata[owner*DATA_W +: DATA_W];
      e.mdin[owner*DATA_W +: DATA_W] = drv_rdata;
    end
    return e;
  endfunction

  task automatic apply_drv();
    if_rr.bus_request = drv_req;   if_fp.bus_request = drv_req;
    if_rr.m_addr = drv_addr;       if_fp.m_addr = drv_addr;
    if_rr.m_cmd = drv_cmd;         if_fp.m_cmd = drv_cmd;
    if_rr.m_dataout = drv_wdata;   if_fp.m_dataout = drv_wdata;
    if_rr.sdram_dataout = drv_rdata; if_fp.sdram_dataout = drv_rdata;
  endtask

  // One clock of stimulus: drive at negedge, predict post-edge outputs.
  task automatic cycle(input logic [N-1:0] req, input logic rst, input bit rand_data);
    @(negedge clk0);
    drv_req = req;
    reset   = rst;
    if (rand_data) begin
      drv_addr  = {$urandom, $urandom, $urandom};
      drv_cmd   = 12'($urandom);
      drv_wdata = {$urandom, $urandom, $urandom, $urandom};
      drv_rdata = $urandom;
    end
    apply_drv();
    model_step(0, req, rst);
    model_step(1, req, rst);
    q_rr.push_back(make_exp(m_owner[0]));
    q_fp.push_back(make_exp(m_owner[1]));
  endtask

  // Monitor: after each rising edge, pop expectations and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk0);
      #1;
      if (q_rr.size() > 0) begin
        e = q_rr.pop_front();
        chk("rr_grant", if_rr.bus_grant, e.grant);
        chk("rr_valid", if_rr.grant_valid, |e.grant);
        chk("rr_gid", if_rr.grant_id, e.gid);
        chk("rr_addr", if_rr.sdram_addr, e.addr);
        chk("rr_cmd", if_rr.sdram_cmd, e.cmd);
        chk("rr_sdram_datain", if_rr.sdram_datain, e.sdin);
        chk("rr_m_datain", if_rr.m_datain, e.mdin);
      end
      if (q_fp.size() > 0) begin
        e = q_fp.pop_front();
        chk("fp_grant", if_fp.bus_grant, e.grant);
        chk("fp_valid", if_fp.grant_valid, |e.grant);
        chk("fp_gid", if_fp.grant_id, e.gid);
        chk("fp_addr", if_fp.sdram_addr, e.addr);
        chk("fp_cmd", if_fp.sdram_cmd, e.cmd);
        chk("fp_sdram_datain", if_fp.sdram_datain, e.sdin);
        chk("fp_m_datain", if_fp.m_datain, e.mdin);
      end
      if (rec_order && if_rr.grant_valid && !prev_valid_rr) seen_ids.push_back(int'(if_rr.grant_id));
      prev_valid_rr = if_rr.grant_valid;
    end
  end

  initial begin
    int exp_order[5];
    logic [N-1:0] r;
    exp_order = '{0, 1, 2, 3, 0};
    reset     = 1'b1;
    drv_req   = '0;
    drv_addr  = '0;
    drv_cmd   = '0;
    drv_wdata = '0;
    drv_rdata = '0;
    apply_drv();
    model_step(0, '0, 1'b1);
    model_step(1, '0, 1'b1);

    // reset, then idle bus
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0000, 1'b1, 1'b1);
    repeat (5) cycle(4'b0000, 1'b0, 1'b1);

    // RR order: everyone requests, owner drops after 2 granted cycles
    rec_order = 1'b1;
    for (int c = 0; c < 16; c++) begin
      r = 4'b1111;
      if (m_owner[0] >= 0 && m_cyc[0] >= 2) r[m_owner[0]] = 1'b0;
      cycle(r, 1'b0, 1'b1);
    end
    rec_order = 1'b0;
    for (int i = 0; i < 5; i++)
      chk("rr_order", (i < seen_ids.size()) ? 32'(seen_ids[i]) : 32'd99, 32'(exp_order[i]));

    // fixed priority 1010 -> 1, then drop bit 1 -> 3
    cycle(4'b0000, 1'b1, 1'b1);
    repeat (3) cycle(4'b1010, 1'b0, 1'b1);
    repeat (3) cycle(4'b1000, 1'b0, 1'b1);
    chk("fp_gid_after_drop", if_fp.grant_id, 2'd3);

    // hold limit: master 2 alone, master 0 joins later
    cycle(4'b0000, 1'b1, 1'b1);
    repeat (10) cycle(4'b0100, 1'b0, 1'b1);
    repeat (6) cycle(4'b0101, 1'b0, 1'b1);
    repeat (2) cycle(4'b0000, 1'b0, 1'b1);

    // datapath steering with fixed values on master 1
    cycle(4'b0000, 1'b1, 1'b1);
    drv_addr[1*ADDR_W +: ADDR_W] = 24'hABCDEF;
    drv_cmd[1*CMD_W +: CMD_W]    = 3'h2;
    drv_rdata                    = 32'h12345678;
    repeat (2) cycle(4'b0010, 1'b0, 1'b0);
    chk("dp_addr_direct", if_rr.sdram_addr, 24'hABCDEF);
    chk("dp_cmd_direct", if_rr.sdram_cmd, 3'h2);
    chk("dp_mdin_direct", if_rr.m_datain, {32'h0, 32'h0, 32'h12345678, 32'h0});

    // reset mid-grant, then all request -> master 0 first in RR
    repeat (3) cycle(4'b1111, 1'b0, 1'b1);
    cycle(4'b1111, 1'b1, 1'b1);
    chk("reset_mid_grant", if_rr.bus_grant, 4'b0000);
    repeat (3) cycle(4'b1111, 1'b0, 1'b1);

    // randomized traffic with occasional reset
    r = '0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      cycle(r, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, 1'b1);
    end

    repeat (2) cycle(4'b0000, 1'b0, 1'b1);
    @(posedge clk0);
    #2;
    chk("sb_drain", 32'(q_rr.size() + q_fp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
